// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch over a req/ack memory port into a small FIFO,
// presenting the head {pc, instr} to IF/ID and restarting at the target on a redirect.
module instr_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic                    stall,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0]       NOP_C   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e             state_r;
    state_e             stateNext_s;
    logic               memReq_r;
    logic               memReqNext_s;
    logic [31:0]        fetchPc_r;
    logic [31:0]        fetchPcNext_s;
    logic [31:0]        reqAddr_r;
    logic [31:0]        reqAddrNext_s;
    logic [PTR_W-1:0]   rdPtr_r;
    logic [PTR_W-1:0]   wrPtr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   countNext_s;
    logic [31:0]        pcMem_r    [DEPTH];
    logic [31:0]        instrMem_r [DEPTH];
    logic               push_s;
    logic               pop_s;

    // FIFO control: a redirect flushes and wins over any push or pop in the same cycle
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        countNext_s = count_r;
        if (redirect) begin
            countNext_s = '0;
        end else begin
            push_s      = (state_r == ST_REQ) && mem_ack;
            pop_s       = (count_r != '0) && !stall;
            countNext_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // State register plus registered request strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            memReq_r <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            memReq_r <= memReqNext_s;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    stateNext_s = ST_IDLE;
                end else if (countNext_s < DEPTH_C) begin
                    stateNext_s = ST_REQ;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    stateNext_s = mem_ack ? ST_IDLE : ST_DISCARD;
                end else if (mem_ack) begin
                    stateNext_s = (countNext_s < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else begin
                    stateNext_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) begin
                    stateNext_s = ST_IDLE;
                end else begin
                    stateNext_s = ST_DISCARD;
                end
            end
            default: stateNext_s = ST_IDLE;
        endcase
    end

    // Output/datapath decode: request address only moves when a new request is launched
    always_comb begin
        memReqNext_s  = (stateNext_s == ST_REQ) || (stateNext_s == ST_DISCARD);
        reqAddrNext_s = reqAddr_r;
        fetchPcNext_s = fetchPc_r;
        if (redirect) begin
            fetchPcNext_s = redirect_pc;
        end else if (push_s) begin
            fetchPcNext_s = fetchPc_r + 32'd4;
        end else begin
            fetchPcNext_s = fetchPc_r;
        end
        if ((state_r == ST_IDLE) && (stateNext_s == ST_REQ)) begin
            reqAddrNext_s = fetchPc_r;
        end else if (push_s && (stateNext_s == ST_REQ)) begin
            reqAddrNext_s = fetchPc_r + 32'd4;
        end else begin
            reqAddrNext_s = reqAddr_r;
        end
    end

    // Fetch PC, request address, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetchPc_r <= RESET_PC;
            reqAddr_r <= RESET_PC;
            rdPtr_r   <= '0;
            wrPtr_r   <= '0;
            count_r   <= '0;
        end else begin
            fetchPc_r <= fetchPcNext_s;
            reqAddr_r <= reqAddrNext_s;
            count_r   <= countNext_s;
            if (redirect) begin
                rdPtr_r <= '0;
                wrPtr_r <= '0;
            end else begin
                wrPtr_r <= push_s ? wrPtr_r + PTR_W'(1'b1) : wrPtr_r;
                rdPtr_r <= pop_s  ? rdPtr_r + PTR_W'(1'b1) : rdPtr_r;
            end
        end
    end

    // Entry storage; contents are meaningless until covered by count
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            pcMem_r[wrPtr_r]    <= fetchPc_r;
            instrMem_r[wrPtr_r] <= mem_rdata;
        end
    end

    assign mem_req     = memReq_r;
    assign mem_addr    = reqAddr_r;
    assign count       = count_r;
    assign instr_valid = (count_r != '0);
    assign instr       = instr_valid ? instrMem_r[rdPtr_r] : NOP_C;
    assign instr_pc    = instr_valid ? pcMem_r[rdPtr_r]    : 32'h0000_0000;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios then randomized traffic, all checked
// against a queue-based reference model of the fetch buffer.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [63:0] q[$];
    logic [31:0] mFetchPc  = RESET_PC;
    logic [31:0] mReqAddr  = RESET_PC;
    bit          mOut      = 1'b0;
    bit          mDiscard  = 1'b0;
    int          memWait   = 0;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock using the currently driven inputs
    task automatic modelStep();
        bit popOk;
        bit pushNow;
        if (!rst) begin
            q.delete();
            mFetchPc = RESET_PC;
            mOut     = 1'b0;
            mDiscard = 1'b0;
            return;
        end
        popOk = (q.size() != 0) && !stall;
        if (redirect) begin
            q.delete();
            mFetchPc = redirect_pc;
            if (mOut) begin
                if (mem_ack) begin
                    mOut = 1'b0; mDiscard = 1'b0;
                end else begin
                    mDiscard = 1'b1;
                end
            end
        end else begin
            pushNow = mOut && !mDiscard && mem_ack;
            if (popOk) void'(q.pop_front());
            if (pushNow) begin
                q.push_back({mFetchPc, mem_rdata});
                mFetchPc = mFetchPc + 32'd4;
            end
            if (mOut && mDiscard) begin
                if (mem_ack) begin
                    mOut = 1'b0; mDiscard = 1'b0;
                end
            end else if (pushNow) begin
                if (q.size() < DEPTH) mReqAddr = mFetchPc;
                else                  mOut = 1'b0;
            end else if (!mOut) begin
                if (q.size() < DEPTH) begin
                    mOut = 1'b1; mReqAddr = mFetchPc;
                end
            end
        end
    endtask

    task automatic checkOutputs();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : {32'h0000_0000, NOP};
        chk("m_req", 64'(mem_req), 64'(mOut));
        if (mOut) chk("m_addr", 64'(mem_addr), 64'(mReqAddr));
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_valid", 64'(instr_valid), 64'(q.size() != 0));
        chk("m_instr", 64'(instr), 64'(head[31:0]));
        chk("m_pc", 64'(instr_pc), 64'(head[63:32]));
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

        // reset values
        cycle(); cycle();
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_instr", 64'(instr), 64'(NOP));
        chk("rst_pc", 64'(instr_pc), 64'd0);
        chk("rst_cnt", 64'(count), 64'd0);

        // streaming with ack every cycle
        rst = 1'b1;
        cycle();
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'h0);
        for (int i = 0; i < 8; i++) begin
            mem_ack = 1'b1; mem_rdata = memData(mReqAddr);
            cycle();
            chk("seq_addr", 64'(mem_addr), 64'(4 * (i + 1)));
            chk("seq_pc", 64'(instr_pc), 64'(4 * i));
            chk("seq_cnt_le1", 64'(count <= 3'd1), 64'd1);
        end

        // fill under stall, then drain in order
        rst = 1'b0; mem_ack = 1'b0;
        cycle();
        rst = 1'b1; stall = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            mem_ack = mOut; mem_rdata = memData(mReqAddr);
            cycle();
        end
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_req", 64'(mem_req), 64'd0);
        mem_ack = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(instr_pc), 64'(4 * i));
            cycle();
            if (i == 0) chk("resume_addr", 64'(mem_addr), 64'h10);
        end

        // three-cycle ack latency
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b0;
            cycle();
            chk("lat_addr", 64'(mem_addr), 64'h10);
            chk("lat_req", 64'(mem_req), 64'd1);
        end
        mem_ack = 1'b1; mem_rdata = memData(32'h10);
        cycle();
        chk("lat_cnt", 64'(count), 64'd1);
        chk("lat_next", 64'(mem_addr), 64'h14);
        mem_ack = 1'b0;
        cycle();
        chk("lat_one_push", 64'(count), 64'd1);

        // redirect with request outstanding, stale ack discarded
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        chk("rd1_cnt", 64'(count), 64'd0);
        chk("rd1_valid", 64'(instr_valid), 64'd0);
        chk("rd1_hold", 64'(mem_addr), 64'h14);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("rd1_stale_cnt", 64'(count), 64'd0);
        mem_ack = 1'b0;
        cycle();
        chk("rd1_addr", 64'(mem_addr), 64'h100);
        mem_ack = 1'b1; mem_rdata = memData(32'h100);
        cycle();
        chk("rd1_pc", 64'(instr_pc), 64'h100);
        chk("rd1_instr", 64'(instr), 64'(memData(32'h100)));

        // redirect coinciding with ack and pop
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        mem_ack = 1'b1; mem_rdata = memData(32'h104);
        cycle();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("rd2_cnt", 64'(count), 64'd0);
        cycle();
        chk("rd2_addr", 64'(mem_addr), 64'h200);

        // reset during an outstanding request; late ack ignored in IDLE
        rst = 1'b0;
        cycle();
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_cnt", 64'(count), 64'd0);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        cycle();
        chk("mid_rst_addr", 64'(mem_addr), 64'(RESET_PC));
        chk("mid_rst_noack", 64'(count), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) != 0);
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if (mOut) begin
                if (memWait == 0) begin
                    mem_ack = 1'b1;
                    memWait = int'($urandom_range(0, 3));
                end else begin
                    mem_ack = 1'b0;
                    memWait--;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                memWait = int'($urandom_range(0, 3));
            end
            mem_rdata = mem_ack ? memData(mReqAddr) : $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch-side front end that sits directly upstream of the pipelined datapath's IF stage.
- Replaces the zero-latency instruction memory path with a request/acknowledge interface to a multi-cycle instruction memory.
- Prefetches sequential instructions into a small FIFO and presents the head {pc, instr} to the IF/ID register.
- On a branch/jump redirect from the execute stage it flushes the FIFO and restarts fetch at the target.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >= 2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  fetch address, valid while mem_req=1
mem_ack  input  1  memory has returned data for the current request
mem_rdata  input  32  instruction word, valid when mem_ack=1
redirect  input  1  PC redirect from execute stage (taken branch/jump)
redirect_pc  input  32  redirect target, sampled when redirect=1
stall  input  1  IF stage stalled (stallF); head must not be consumed
instr_valid  output  1  head entry valid (count != 0)
instr  output  32  head instruction; 32'h00000013 (NOP) when empty
instr_pc  output  32  PC of head instruction; 0 when empty
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0 at clock edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty, count=0.
  - mem_req=0, instr_valid=0, instr=NOP, instr_pc=0.
  - Reset mid-request abandons the transaction; any ack arriving afterwards in IDLE is ignored.
- FIFO:
  - Circular, DEPTH entries of {pc[31:0], instr[31:0]}; read/write pointers wrap modulo DEPTH.
  - Head outputs are combinational from the read pointer.
- Pop: instr_valid=1 and stall=0 at the clock edge -> read pointer advances.
- Push: accepted ack in REQ -> write {fetch_pc, mem_rdata}, fetch_pc += 4 (wraps mod 2^32).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Never push when full. Space is guaranteed because REQ is entered only when count_next < DEPTH.
- State machine (mem_req = state in {REQ, DISCARD}; mem_addr = req_addr register):
  - IDLE:
    - redirect -> fetch_pc=redirect_pc, flush, stay IDLE.
    - Else if count_next < DEPTH -> req_addr=fetch_pc, go REQ.
  - REQ:
    - redirect & ~mem_ack -> flush, fetch_pc=redirect_pc, go DISCARD.
    - redirect & mem_ack -> data dropped, flush, fetch_pc=redirect_pc, go IDLE.
    - mem_ack -> push; if count after push/pop < DEPTH, req_addr=fetch_pc+4 and stay REQ (back-to-back, one fetch per cycle); else go IDLE.
    - No ack -> hold; mem_req and mem_addr remain stable until ack.
  - DISCARD:
    - mem_req and mem_addr are held at the stale address until mem_ack.
    - Ack data is dropped; go IDLE.
    - A further redirect here only updates fetch_pc.
- Redirect priority: redirect overrides push and pop in the same cycle.
  - FIFO empty and count=0 on the next cycle; instr_valid=0 that cycle.
- Latency:
  - Redirect at edge N -> target in REQ at edge N+1 (from IDLE path) -> earliest instr_valid for target the cycle after its ack.
  - Reset release -> first mem_req one cycle after rst deasserts.
- At most one outstanding request; mem_ack outside REQ/DISCARD is ignored.

Test Plan:
- Reset then mem_ack=1 every cycle, stall=0 -> mem_addr sequence 0x0, 0x4, 0x8…; instr_pc follows with instr_valid=1 from the cycle after the first ack; count stays <= 1.
- stall=1 with ack every cycle, DEPTH=4 -> count reaches 4, state IDLE, mem_req=0; release stall -> entries pop at 0x0, 0x4, 0x8, 0xC in order and fetch resumes at 0x10.
- 3-cycle ack latency -> mem_addr held constant for 3 cycles; one push per request.
- Redirect to 0x100 while in REQ with no ack -> count=0 next cycle; stale ack data is discarded; next mem_addr=0x100; first valid instr_pc=0x100.
- Redirect to 0x200 in the same cycle as mem_ack and a pop -> nothing pushed, count=0, next request at 0x200.
- rst=0 asserted during an outstanding request -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
